elastic_config_loader: RTL and testbench
========================================

ELASTIC_CONFIG_LOADER -- requirements
Module: elastic_config_loader

Interface
REQ-001 SHALL have parameter PE_NUM, default 16, number of PEs served.
REQ-002 SHALL have parameter PE_ID_WIDTH, default 4, width of PE id (log2 PE_NUM).
REQ-003 SHALL have parameters NEIGHBOR_PE_NUM=4, NEIGHBOR_PE_NUM_BIT_LENGTH=2, OPERATION_BIT_LENGTH=4, DATA_WIDTH=32, CONTEXT_SIZE_BIT_LENGTH=3, with the same meanings as in the PE config port.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk (input, 1 bit, clock) and reset_n (input, 1 bit, asynchronous active-low reset).
REQ-005 SHALL have host-side SELF input ports: host_valid (input, 1), host_stop (output, 1), host_last (input, 1, final record of the load).
REQ-006 SHALL have host record fields: host_pe_id (input, PE_ID_WIDTH), host_context_id (input, CONTEXT_SIZE_BIT_LENGTH), host_input_index_1 and host_input_index_2 (input, NEIGHBOR_PE_NUM_BIT_LENGTH each), host_output_index (input, NEIGHBOR_PE_NUM, one bit per neighbor), host_op (input, OPERATION_BIT_LENGTH), host_const_data (input, DATA_WIDTH).
REQ-007 SHALL have control inputs: load_start (input, 1, begin load) and context_max_id (input, CONTEXT_SIZE_BIT_LENGTH, sampled on load_start).
REQ-008 SHALL have PE-side config outputs, all registered: config_input_PE_index_1/2, config_output_PE_index, config_op, config_const_data, config_index (widths as in REQ-006), and write_config_data (output, PE_NUM, one-hot per PE).
REQ-009 SHALL have execution outputs: start_exec (output, 1), mapping_context_max_id (output, CONTEXT_SIZE_BIT_LENGTH).
REQ-010 SHALL have status outputs: busy (output, 1), error (output, 1), record_count (output, 16).

Function
REQ-011 SHALL implement an FSM with states IDLE, LOAD, START, RUN.
REQ-012 IDLE or RUN plus load_start: go to LOAD; latch context_max_id into mapping_context_max_id; clear record_count and error.
REQ-013 load_start while in LOAD or START SHALL be ignored.
REQ-014 host_stop SHALL be 0 only in LOAD; in every other state it is 1.
REQ-015 A record SHALL be accepted exactly when host_valid=1, host_stop=0 and the state is LOAD.
REQ-016 Accepted valid record at cycle t: config_* fields equal the record at t+1, write_config_data has bit host_pe_id set for exactly that one cycle, and record_count increments.
REQ-017 A record is invalid if host_pe_id >= PE_NUM or host_context_id > mapping_context_max_id; invalid records SHALL be dropped (write_config_data stays 0), error set sticky, record_count not incremented.
REQ-018 An accepted record with host_last=1 SHALL move the FSM to START; this applies whether or not the record is valid.
REQ-019 START SHALL last exactly one cycle, with start_exec=1, then go to RUN; start_exec is 0 in all other cycles.
REQ-020 The START cycle SHALL be no earlier than the cycle after the final write pulse, so each PE sees its last write before start_exec.
REQ-021 busy SHALL be 1 in LOAD and START, and 0 in IDLE and RUN.
REQ-022 write_config_data SHALL be 0 on every cycle without an accepted valid record in the preceding cycle.
REQ-023 config_* fields SHALL hold their last value when not writing.
REQ-024 record_count SHALL saturate at 16'hFFFF.
REQ-025 host_valid=1 outside LOAD SHALL have no effect.

Reset
REQ-026 reset_n=0 SHALL immediately force:
- state IDLE
- all config_* outputs, write_config_data, mapping_context_max_id, record_count 0
- start_exec, error, busy 0
- host_stop 1
REQ-027 Reset asserted mid-LOAD SHALL abort the load: no further write pulse and no start_exec are issued.

Verification
REQ-028 Basic load: load_start with context_max_id=2; records (pe 3, ctx 0, op 1), (pe 3, ctx 1, op 5, const 0x55), (pe 7, ctx 2, op 8, last) -> write_config_data = 0x0008, 0x0008, 0x0080 on successive cycles, config_index 0,1,2, start_exec one cycle after the last write, record_count=3, mapping_context_max_id=2.
REQ-029 Invalid records: max_id=1; record (pe 20 on PE_NUM=16), then (pe 2, ctx 3) -> no write pulses, error=1, record_count=0; then (pe 2, ctx 1, last) -> write 0x0004, start_exec pulse, error stays 1.
REQ-030 Host gaps: host_valid toggled 1,0,1 with last on the third cycle -> exactly two write pulses, aligned one cycle after each accepted record.
REQ-031 Ignored restarts: load_start during LOAD -> count not cleared; load_start in RUN -> error cleared, busy=1, new load accepted; host_valid in IDLE -> host_stop=1, no write.
REQ-032 Reset mid-load: reset_n low for one cycle after the 2nd of 4 records -> outputs zero immediately, no start_exec, state IDLE, host_stop=1.

Source files
------------

// File: rtl/elastic_config_loader.sv
// ----------------------------------------------------------------------------
// elastic_config_loader
//
// Purpose:
//   Streams configuration records from a host into an array of PEs. The host
//   presents one record per cycle with host_valid; the loader accepts records
//   while in LOAD. For each valid record it broadcasts the config fields and
//   raises a one-hot write strobe for the target PE. It drops records that
//   address a non-existent PE or a context above the latched maximum, and
//   flags them as errors. The record marked host_last ends the load: after
//   its write pulse has been seen, start_exec is raised for one cycle and the
//   array runs until the next load_start.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   load_start              begin a new load (honoured in IDLE and RUN only)
//   context_max_id          highest legal context id, sampled on load_start
//   host_valid/host_stop    host handshake; a record moves when valid & !stop
//   host_last               marks the final record of the load
//   host_*                  record fields (PE id, context, indices, op, const)
//   config_*                registered record fields broadcast to the PEs
//   write_config_data       one-hot write strobe, one bit per PE
//   start_exec              one-cycle pulse that starts execution
//   mapping_context_max_id  context_max_id latched for the current mapping
//   busy                    high while loading or starting
//   error                   sticky flag: at least one record was dropped
//   record_count            number of records written, saturating
// ----------------------------------------------------------------------------
module elastic_config_loader #(
    parameter int PE_NUM                     = 16,
    parameter int PE_ID_WIDTH                = 4,
    parameter int NEIGHBOR_PE_NUM            = 4,
    parameter int NEIGHBOR_PE_NUM_BIT_LENGTH = 2,
    parameter int OPERATION_BIT_LENGTH       = 4,
    parameter int DATA_WIDTH                 = 32,
    parameter int CONTEXT_SIZE_BIT_LENGTH    = 3
) (
    input  logic                                  clk,
    input  logic                                  reset_n,

    input  logic                                  host_valid,
    output logic                                  host_stop,
    input  logic                                  host_last,
    input  logic [PE_ID_WIDTH-1:0]                host_pe_id,
    input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    host_context_id,
    input  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] host_input_index_1,
    input  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] host_input_index_2,
    input  logic [NEIGHBOR_PE_NUM-1:0]            host_output_index,
    input  logic [OPERATION_BIT_LENGTH-1:0]       host_op,
    input  logic [DATA_WIDTH-1:0]                 host_const_data,

    input  logic                                  load_start,
    input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    context_max_id,

    output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] config_input_PE_index_1,
    output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] config_input_PE_index_2,
    output logic [NEIGHBOR_PE_NUM-1:0]            config_output_PE_index,
    output logic [OPERATION_BIT_LENGTH-1:0]       config_op,
    output logic [DATA_WIDTH-1:0]                 config_const_data,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    config_index,
    output logic [PE_NUM-1:0]                     write_config_data,

    output logic                                  start_exec,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    mapping_context_max_id,

    output logic                                  busy,
    output logic                                  error,
    output logic [15:0]                           record_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_START = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    localparam logic [31:0]       PE_NUM_U = PE_NUM;
    localparam logic [PE_NUM-1:0] ONE_HOT0 = {{(PE_NUM-1){1'b0}}, 1'b1};

    state_t                                r_state;
    // Set after the last record is accepted: LOAD is held one more cycle
    // (with host_stop raised) so the final write pulse precedes start_exec.
    logic                                  r_drain;
    logic                                  r_host_stop;
    logic                                  r_busy;
    logic                                  r_start_exec;
    logic                                  r_error;
    logic [15:0]                           r_record_count;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    r_max_id;
    logic [PE_NUM-1:0]                     r_write;
    logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] r_in_idx_1;
    logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] r_in_idx_2;
    logic [NEIGHBOR_PE_NUM-1:0]            r_out_idx;
    logic [OPERATION_BIT_LENGTH-1:0]       r_op;
    logic [DATA_WIDTH-1:0]                 r_const;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    r_index;

    logic                                  w_accept;
    logic                                  w_rec_ok;
    logic [PE_NUM-1:0]                     w_onehot;

    assign w_accept = host_valid && !r_host_stop && (r_state == S_LOAD);
    // Zero-extend the id so ids wider than PE_NUM's range compare correctly.
    assign w_rec_ok = ({{(32-PE_ID_WIDTH){1'b0}}, host_pe_id} < PE_NUM_U) &&
                      (host_context_id <= r_max_id);
    assign w_onehot = ONE_HOT0 << host_pe_id;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_drain        <= 1'b0;
            r_host_stop    <= 1'b1;
            r_busy         <= 1'b0;
            r_start_exec   <= 1'b0;
            r_error        <= 1'b0;
            r_record_count <= '0;
            r_max_id       <= '0;
            r_write        <= '0;
            r_in_idx_1     <= '0;
            r_in_idx_2     <= '0;
            r_out_idx      <= '0;
            r_op           <= '0;
            r_const        <= '0;
            r_index        <= '0;
        end else begin
            r_write <= '0;
            case (r_state)
                S_IDLE, S_RUN: begin
                    if (load_start) begin
                        r_state        <= S_LOAD;
                        r_max_id       <= context_max_id;
                        r_record_count <= '0;
                        r_error        <= 1'b0;
                        r_drain        <= 1'b0;
                        r_host_stop    <= 1'b0;
                        r_busy         <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (r_drain) begin
                        r_state      <= S_START;
                        r_drain      <= 1'b0;
                        r_start_exec <= 1'b1;
                    end else if (w_accept) begin
                        if (w_rec_ok) begin
                            r_write    <= w_onehot;
                            r_in_idx_1 <= host_input_index_1;
                            r_in_idx_2 <= host_input_index_2;
                            r_out_idx  <= host_output_index;
                            r_op       <= host_op;
                            r_const    <= host_const_data;
                            r_index    <= host_context_id;
                            if (r_record_count != 16'hFFFF) begin
                                r_record_count <= r_record_count + 16'd1;
                            end
                        end else begin
                            r_error <= 1'b1;
                        end
                        if (host_last) begin
                            r_drain     <= 1'b1;
                            r_host_stop <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    r_state      <= S_RUN;
                    r_start_exec <= 1'b0;
                    r_busy       <= 1'b0;
                    r_host_stop  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign host_stop               = r_host_stop;
    assign busy                    = r_busy;
    assign start_exec              = r_start_exec;
    assign error                   = r_error;
    assign record_count            = r_record_count;
    assign mapping_context_max_id  = r_max_id;
    assign write_config_data       = r_write;
    assign config_input_PE_index_1 = r_in_idx_1;
    assign config_input_PE_index_2 = r_in_idx_2;
    assign config_output_PE_index  = r_out_idx;
    assign config_op               = r_op;
    assign config_const_data       = r_const;
    assign config_index            = r_index;

endmodule

// File: tb/tb_elastic_config_loader.sv
// ----------------------------------------------------------------------------
// tb_elastic_config_loader
//
// Purpose:
//   Directed, table-driven bench for elastic_config_loader. Each table row
//   holds the inputs for one clock cycle and the outputs expected just after
//   that edge. Reset behaviour is exercised by hand-written sequences.
//   The DUT is built with PE_ID_WIDTH=5 so out-of-range PE ids can be driven.
// ----------------------------------------------------------------------------
module tb_elastic_config_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        host_valid, host_stop, host_last;
    logic [4:0]  host_pe_id;
    logic [2:0]  host_context_id;
    logic [1:0]  host_input_index_1, host_input_index_2;
    logic [3:0]  host_output_index;
    logic [3:0]  host_op;
    logic [31:0] host_const_data;
    logic        load_start;
    logic [2:0]  context_max_id;
    logic [1:0]  config_input_PE_index_1, config_input_PE_index_2;
    logic [3:0]  config_output_PE_index;
    logic [3:0]  config_op;
    logic [31:0] config_const_data;
    logic [2:0]  config_index;
    logic [15:0] write_config_data;
    logic        start_exec;
    logic [2:0]  mapping_context_max_id;
    logic        busy, error;
    logic [15:0] record_count;

    int n_chk = 0;
    int n_err = 0;

    elastic_config_loader #(
        .PE_NUM(16), .PE_ID_WIDTH(5), .NEIGHBOR_PE_NUM(4),
        .NEIGHBOR_PE_NUM_BIT_LENGTH(2), .OPERATION_BIT_LENGTH(4),
        .DATA_WIDTH(32), .CONTEXT_SIZE_BIT_LENGTH(3)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .host_valid(host_valid), .host_stop(host_stop), .host_last(host_last),
        .host_pe_id(host_pe_id), .host_context_id(host_context_id),
        .host_input_index_1(host_input_index_1),
        .host_input_index_2(host_input_index_2),
        .host_output_index(host_output_index), .host_op(host_op),
        .host_const_data(host_const_data),
        .load_start(load_start), .context_max_id(context_max_id),
        .config_input_PE_index_1(config_input_PE_index_1),
        .config_input_PE_index_2(config_input_PE_index_2),
        .config_output_PE_index(config_output_PE_index),
        .config_op(config_op), .config_const_data(config_const_data),
        .config_index(config_index), .write_config_data(write_config_data),
        .start_exec(start_exec), .mapping_context_max_id(mapping_context_max_id),
        .busy(busy), .error(error), .record_count(record_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ls;
        logic [2:0]  mx;
        logic        v;
        logic        lst;
        logic [4:0]  pe;
        logic [2:0]  ctx;
        logic [3:0]  op;
        logic [31:0] cd;
        logic [15:0] ewr;
        logic [2:0]  eidx;
        logic [3:0]  eop;
        logic [31:0] ecd;
        logic        est;
        logic        ebusy;
        logic        estop;
        logic        eerr;
        logic [15:0] ecnt;
        logic [2:0]  emx;
    } vec_t;

    function automatic vec_t mk(int ls, int mx, int v, int lst, int pe, int ctx,
                                int op, int cd, int ewr, int eidx, int eop,
                                int ecd, int est, int eb, int es, int ee,
                                int ecnt, int emx);
        vec_t r;
        r.ls = 1'(ls);     r.mx = 3'(mx);     r.v = 1'(v);     r.lst = 1'(lst);
        r.pe = 5'(pe);     r.ctx = 3'(ctx);   r.op = 4'(op);   r.cd = 32'(cd);
        r.ewr = 16'(ewr);  r.eidx = 3'(eidx); r.eop = 4'(eop); r.ecd = 32'(ecd);
        r.est = 1'(est);   r.ebusy = 1'(eb);  r.estop = 1'(es); r.eerr = 1'(ee);
        r.ecnt = 16'(ecnt); r.emx = 3'(emx);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Index fields follow the op so they can be predicted from the expected op.
    task automatic drive(input logic ls, input logic [2:0] mx, input logic v,
                         input logic lst, input logic [4:0] pe,
                         input logic [2:0] ctx, input logic [3:0] op,
                         input logic [31:0] cd);
        load_start         = ls;
        context_max_id     = mx;
        host_valid         = v;
        host_last          = lst;
        host_pe_id         = pe;
        host_context_id    = ctx;
        host_op            = op;
        host_input_index_1 = op[1:0];
        host_input_index_2 = op[3:2];
        host_output_index  = op;
        host_const_data    = cd;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " wr"},    64'(write_config_data), 64'd0);
        chk({tag, " start"}, 64'(start_exec),        64'd0);
        chk({tag, " stop"},  64'(host_stop),         64'd1);
        chk({tag, " busy"},  64'(busy),              64'd0);
    endtask

    vec_t tbl[20];

    initial begin
        // ls mx v lst pe ctx op cd | wr idx op cd st busy stop err cnt mx
        tbl[0]  = mk(0,0,1,0, 3,0,1,0,        'h0000,0,0,0,        0,0,1,0,0,0); // valid in IDLE
        tbl[1]  = mk(1,2,0,0, 0,0,0,0,        'h0000,0,0,0,        0,1,0,0,0,2);
        tbl[2]  = mk(0,0,1,0, 3,0,1,0,        'h0008,0,1,0,        0,1,0,0,1,2);
        tbl[3]  = mk(0,0,1,0, 3,1,5,'h55,     'h0008,1,5,'h55,     0,1,0,0,2,2);
        tbl[4]  = mk(0,0,1,1, 7,2,8,0,        'h0080,2,8,0,        0,1,1,0,3,2);
        tbl[5]  = mk(0,0,0,0, 0,0,0,0,        'h0000,2,8,0,        1,1,1,0,3,2);
        tbl[6]  = mk(0,0,0,0, 0,0,0,0,        'h0000,2,8,0,        0,0,1,0,3,2);
        tbl[7]  = mk(1,1,0,0, 0,0,0,0,        'h0000,2,8,0,        0,1,0,0,0,1); // restart from RUN
        tbl[8]  = mk(0,0,1,0, 20,0,3,0,       'h0000,2,8,0,        0,1,0,1,0,1); // pe out of range
        tbl[9]  = mk(0,0,1,0, 2,3,3,0,        'h0000,2,8,0,        0,1,0,1,0,1); // ctx > max
        tbl[10] = mk(0,0,1,1, 2,1,4,'hAA,     'h0004,1,4,'hAA,     0,1,1,1,1,1);
        tbl[11] = mk(0,0,0,0, 0,0,0,0,        'h0000,1,4,'hAA,     1,1,1,1,1,1);
        tbl[12] = mk(0,0,0,0, 0,0,0,0,        'h0000,1,4,'hAA,     0,0,1,1,1,1);
        tbl[13] = mk(0,0,1,0, 1,0,6,0,        'h0000,1,4,'hAA,     0,0,1,1,1,1); // valid in RUN
        tbl[14] = mk(1,3,0,0, 0,0,0,0,        'h0000,1,4,'hAA,     0,1,0,0,0,3);
        tbl[15] = mk(0,0,1,0, 5,3,2,'h11,     'h0020,3,2,'h11,     0,1,0,0,1,3);
        tbl[16] = mk(1,0,0,0, 0,0,0,0,        'h0000,3,2,'h11,     0,1,0,0,1,3); // gap + ignored restart
        tbl[17] = mk(0,0,1,1, 6,0,9,'h22,     'h0040,0,9,'h22,     0,1,1,0,2,3);
        tbl[18] = mk(1,1,0,0, 0,0,0,0,        'h0000,0,9,'h22,     1,1,1,0,2,3); // restart in START ignored
        tbl[19] = mk(0,0,0,0, 0,0,0,0,        'h0000,0,9,'h22,     0,0,1,0,2,3);

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst wr",    64'(write_config_data),      64'd0);
        chk("rst stop",  64'(host_stop),              64'd1);
        chk("rst busy",  64'(busy),                   64'd0);
        chk("rst start", 64'(start_exec),             64'd0);
        chk("rst err",   64'(error),                  64'd0);
        chk("rst cnt",   64'(record_count),           64'd0);
        chk("rst mx",    64'(mapping_context_max_id), 64'd0);
        chk("rst op",    64'(config_op),              64'd0);
        tick();
        tick();
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].ls, tbl[i].mx, tbl[i].v, tbl[i].lst, tbl[i].pe,
                  tbl[i].ctx, tbl[i].op, tbl[i].cd);
            tick();
            chk($sformatf("v%0d wr", i),    64'(write_config_data),       64'(tbl[i].ewr));
            chk($sformatf("v%0d idx", i),   64'(config_index),            64'(tbl[i].eidx));
            chk($sformatf("v%0d op", i),    64'(config_op),               64'(tbl[i].eop));
            chk($sformatf("v%0d in1", i),   64'(config_input_PE_index_1), 64'(tbl[i].eop[1:0]));
            chk($sformatf("v%0d in2", i),   64'(config_input_PE_index_2), 64'(tbl[i].eop[3:2]));
            chk($sformatf("v%0d out", i),   64'(config_output_PE_index),  64'(tbl[i].eop));
            chk($sformatf("v%0d cd", i),    64'(config_const_data),       64'(tbl[i].ecd));
            chk($sformatf("v%0d start", i), 64'(start_exec),              64'(tbl[i].est));
            chk($sformatf("v%0d busy", i),  64'(busy),                    64'(tbl[i].ebusy));
            chk($sformatf("v%0d stop", i),  64'(host_stop),               64'(tbl[i].estop));
            chk($sformatf("v%0d err", i),   64'(error),                   64'(tbl[i].eerr));
            chk($sformatf("v%0d cnt", i),   64'(record_count),            64'(tbl[i].ecnt));
            chk($sformatf("v%0d mx", i),    64'(mapping_context_max_id),  64'(tbl[i].emx));
        end

        // Reset in the middle of a four-record load.
        drive(1, 3, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 0, 1, 0, 1, 'h1);
        tick();
        drive(0, 0, 1, 0, 2, 1, 2, 'h2);
        tick();
        chk("mid wr2",  64'(write_config_data), 64'h0004);
        chk("mid cnt2", 64'(record_count),      64'd2);
        drive(0, 0, 1, 0, 3, 2, 3, 'h3);
        reset_n = 1'b0;
        #1;
        chk("mid rst wr",   64'(write_config_data),      64'd0);
        chk("mid rst stop", 64'(host_stop),              64'd1);
        chk("mid rst busy", 64'(busy),                   64'd0);
        chk("mid rst cnt",  64'(record_count),           64'd0);
        chk("mid rst mx",   64'(mapping_context_max_id), 64'd0);
        chk("mid rst op",   64'(config_op),              64'd0);
        chk("mid rst cd",   64'(config_const_data),      64'd0);
        chk("mid rst idx",  64'(config_index),           64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk_quiet("post rst a");
        drive(0, 0, 1, 1, 4, 0, 4, 'h4);
        tick();
        chk_quiet("post rst b");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_quiet($sformatf("post rst idle%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
